dmem_be_ram: RTL and testbench
==============================

// Module: dmem_be_ram
// PURPOSE
//  Next-generation data memory for the RV32I core: parametrised width/depth single-port RAM with
//  per-byte write enables and a valid/ready request channel. One-entry response buffer for back-pressure.
//  Sits between the LSU (MEM stage) and storage; replaces the fixed 512x128 DMem.
// PARAMETERS
//  DATA_W  128              data width in bits; must be a multiple of 8
//  DEPTH   512              number of words; need not be a power of two
//  ADDR_W  $clog2(DEPTH)    word-address width
//  BE_W    DATA_W/8         byte-enable width (derived; do not override)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when req_valid & req_ready
//  req_we      in   1       1 = write, 0 = read
//  req_addr    in   ADDR_W  word address
//  req_be      in   BE_W    byte enables (writes only; ignored on reads)
//  req_wdata   in   DATA_W  write data
//  resp_valid  out  1       response present
//  resp_ready  in   1       response consumed when resp_valid & resp_ready
//  resp_rdata  out  DATA_W  read data (0 for write responses and errors)
//  resp_err    out  1       address >= DEPTH
//  init_done   out  1       memory usable
// BEHAVIOUR
//  Reset: resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0. init_done=0 with DMEM_INIT_CLEAR_EN, else 1.
//  FSM states: INIT -> IDLE. INIT only with DMEM_INIT_CLEAR_EN; otherwise reset enters IDLE directly.
//  INIT: clear counter 0..DEPTH-1 writes all-zero words, one per cycle; req_ready=0.
//    After word DEPTH-1 is written: IDLE, init_done=1. Takes exactly DEPTH cycles after reset release.
//  IDLE: req_ready = !resp_valid | resp_ready (combinational; single response slot, 100% throughput).
//  Accepted write: mem[a][8i+7:8i] <= wdata byte i for each req_be[i]=1; other bytes unchanged.
//    Next cycle resp_valid=1, resp_rdata=0, resp_err=0.
//  Accepted write with req_be=0: no storage change; still gets a response.
//  Accepted read: next cycle resp_valid=1, resp_rdata=mem[a] (latency 1), resp_err=0.
//  req_addr >= DEPTH: no storage access; response has resp_err=1 and resp_rdata=0.
//  Response regs hold stable while resp_valid & !resp_ready.
//    resp_valid drops the cycle after handshake unless a new request is accepted that same cycle.
//  Read same address as the write accepted in the previous cycle: returns the written (merged) data.
//  Reset asserted mid-INIT or mid-transfer: FSM and response slot drop immediately.
//    An in-flight response is lost. With the macro, INIT restarts from word 0.
//  Storage array itself is not reset.
// CONFIGURATION
//  DMEM_INIT_CLEAR_EN defined: post-reset INIT sweep zeroes every word; init_done low for DEPTH cycles.
//  Undefined: no INIT state; contents undefined until written; init_done tied 1; req_ready valid from first cycle.
// STRUCTURE
//  Shared package dmem_pkg: state enum typedef {ST_INIT, ST_IDLE}.
//  Also in dmem_pkg: DMEM_DATA_W/DMEM_DEPTH defaults.
//  Also in dmem_pkg: function be_merge(old, new, be) returning the byte-masked merge.
//  One sub-module: dmem_be_ram_array. Storage with byte-lane write and registered read.
//    Its write port is shared by the INIT clear path and the request path (mux in parent).
//  Parent holds the FSM, handshake, response slot and range check.
// TESTING
//  Reset, macro on, DEPTH=512: init_done rises exactly 512 cycles after rst_n; any read -> 0, resp_err=0.
//  Write addr 5, be=16'h0001, wdata=..AA, then be=16'h8000, wdata=BB..: read 5 -> BB00..00AA.
//  resp_ready held 0 for 3 cycles after a read:
//    req_ready=0 throughout; resp_rdata stable; release -> next request accepted same cycle.
//  Back-to-back: write addr 7 = 32'hDEADBEEF (full be) then read 7 next cycle -> DEADBEEF, no bubble.
//  DEPTH=300, read/write addr 300 -> resp_err=1, rdata=0; a following read of addr 299 is unchanged.
//  rst_n pulsed low at INIT word 100 -> INIT restarts; init_done after a full 512 cycles from release.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, defaults and byte-merge helper for the data memory
package dmem_pkg;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  localparam int DMEM_DATA_W = 128;
  localparam int DMEM_DEPTH  = 512;

  // Widest word the merge helper handles; narrower words are zero-extended by the caller.
  localparam int DMEM_MAX_W  = 1024;
  localparam int DMEM_MAX_BE = DMEM_MAX_W / 8;

  function automatic logic [DMEM_MAX_W-1:0] be_merge(
    input logic [DMEM_MAX_W-1:0]  old_w,
    input logic [DMEM_MAX_W-1:0]  new_w,
    input logic [DMEM_MAX_BE-1:0] be
  );
    logic [DMEM_MAX_W-1:0] res;
    for (int i = 0; i < DMEM_MAX_BE; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_be_ram_array.sv
// rtl/dmem_be_ram_array.sv - single-port storage with byte-lane write and registered read
module dmem_be_ram_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // rdata only moves on a read, so it stays put while a response is stalled.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= DATA_W'(be_merge(DMEM_MAX_W'(mem[addr]), DMEM_MAX_W'(wdata),
                                      DMEM_MAX_BE'(be)));
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_be_ram.sv
// rtl/dmem_be_ram.sv - byte-enable data RAM with valid/ready request and one-entry response slot
// Optional post-reset clear sweep: DMEM_INIT_CLEAR_EN
module dmem_be_ram
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam logic [ADDR_W:0]   DEPTH_X   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic              accept;
  logic              in_range;
  logic              resp_rd;
  logic              arr_en;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign in_range  = {1'b0, req_addr} < DEPTH_X;
  assign req_ready = rst_n && (state == ST_IDLE) && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

`ifdef DMEM_INIT_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      if (clr_cnt == LAST_WORD) begin
        state     <= ST_IDLE;
        init_done <= 1'b1;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end
`else
  assign state     = ST_IDLE;
  assign init_done = 1'b1;
`endif

  // The clear sweep owns the write port while it runs; requests are held off by req_ready.
  always_comb begin
    arr_en    = accept && in_range;
    arr_we    = req_we;
    arr_addr  = req_addr;
    arr_be    = req_be;
    arr_wdata = req_wdata;
`ifdef DMEM_INIT_CLEAR_EN
    if (state == ST_INIT) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_addr  = clr_cnt;
      arr_be    = '1;
      arr_wdata = '0;
    end
`endif
  end

  dmem_be_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rd    <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err   <= !in_range;
      resp_rd    <= !req_we && in_range;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Write and error responses carry zero data; reads expose the array's registered output.
  assign resp_rdata = (resp_valid && resp_rd) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_be_ram.sv
// tb/tb_dmem_be_ram.sv - scoreboard bench for dmem_be_ram (DEPTH 512 and DEPTH 300 instances)
module tb_dmem_be_ram;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, init_done;
  logic [1:0][8:0]   req_addr;
  logic [1:0][15:0]  req_be;
  logic [1:0][127:0] req_wdata, resp_rdata;

  int checks = 0;
  int errors = 0;
  bit rand_rr = 1'b0;

  typedef struct {
    logic [127:0] rdata;
    logic         err;
    bit           chk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [127:0] mdl [2][512];
  logic [15:0]  kb  [2][512];

  always #5 clk = ~clk;

  dmem_be_ram #(.DATA_W(128), .DEPTH(512)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .init_done(init_done[0])
  );

  dmem_be_ram #(.DATA_W(128), .DEPTH(300)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .init_done(init_done[1])
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 512; a++) begin
        mdl[d][a] = '0;
`ifdef DMEM_INIT_CLEAR_EN
        kb[d][a] = 16'hFFFF;
`else
        kb[d][a] = 16'h0000;
`endif
      end
    end
  endtask

  // Reference behaviour at the moment a request is accepted.
  task automatic push_exp(input int d, input logic we, input logic [8:0] a,
                          input logic [15:0] be, input logic [127:0] wd);
    exp_t e;
    int depth;
    depth = (d == 0) ? 512 : 300;
    if (int'(a) >= depth) begin
      e = '{rdata: '0, err: 1'b1, chk: 1'b1};
    end else if (we) begin
      for (int i = 0; i < 16; i++) begin
        if (be[i]) begin
          mdl[d][a][8*i +: 8] = wd[8*i +: 8];
          kb[d][a][i] = 1'b1;
        end
      end
      e = '{rdata: '0, err: 1'b0, chk: 1'b1};
    end else begin
      e = '{rdata: mdl[d][a], err: 1'b0, chk: (kb[d][a] == 16'hFFFF)};
    end
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic issue(input int d, input logic we, input logic [8:0] a,
                       input logic [15:0] be, input logic [127:0] wd, output int waits);
    bit timed_out;
    timed_out = 1'b0;
    waits = 0;
    req_we[d] = we;
    req_addr[d] = a;
    req_be[d] = be;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready[d]) break;
      waits++;
      if (waits > 100) begin
        checks++;
        errors++;
        $display("FAIL req_accept_timeout inst=%0d actual=no_accept required=accept", d);
        timed_out = 1'b1;
        break;
      end
    end
    if (!timed_out) push_exp(d, we, a, be, wd);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!init_done[0] && n < 2000);
  endtask

  // Monitor: pops on every response handshake and checks slot stability while stalled.
  bit           hold_v  [2];
  logic [127:0] hold_rd [2];
  logic         hold_err[2];

  always @(negedge clk) begin
    exp_t e;
    int   have;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        hold_v[d] = 1'b0;
        continue;
      end
      if (hold_v[d]) begin
        checks++;
        if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== hold_rd[d] || resp_err[d] !== hold_err[d]) begin
          errors++;
          $display("FAIL resp_hold inst=%0d actual=v%0b/%0h/e%0b required=v1/%0h/e%0b",
                   d, resp_valid[d], resp_rdata[d], resp_err[d], hold_rd[d], hold_err[d]);
        end
      end
      if (resp_valid[d] && resp_ready[d]) begin
        have = (d == 0) ? q0.size() : q1.size();
        checks++;
        if (have == 0) begin
          errors++;
          $display("FAIL resp_unexpected inst=%0d actual=response required=none", d);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          if (resp_err[d] !== e.err || (e.chk && resp_rdata[d] !== e.rdata)) begin
            errors++;
            $display("FAIL resp_data inst=%0d actual=%0h/e%0b required=%0h/e%0b",
                     d, resp_rdata[d], resp_err[d], e.rdata, e.err);
          end
        end
      end
      hold_v[d]   = resp_valid[d] && !resp_ready[d];
      hold_rd[d]  = resp_rdata[d];
      hold_err[d] = resp_err[d];
    end
  end

  always @(posedge clk) begin
    if (rand_rr) begin
      #1;
      resp_ready[0] = ($urandom_range(0, 3) != 0);
      resp_ready[1] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int w;
    int n;
    int d;
    logic [8:0]   a;
    logic [15:0]  be;
    logic [127:0] wd;

    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_be     = '0;
    req_wdata  = '0;
    resp_ready = 2'b11;
    model_reset();

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_resp_valid%0d", i), 128'(resp_valid[i]), 128'd0);
      check($sformatf("reset_resp_rdata%0d", i), resp_rdata[i], 128'd0);
      check($sformatf("reset_resp_err%0d", i), 128'(resp_err[i]), 128'd0);
      check($sformatf("reset_req_ready%0d", i), 128'(req_ready[i]), 128'd0);
`ifdef DMEM_INIT_CLEAR_EN
      check($sformatf("reset_init_done%0d", i), 128'(init_done[i]), 128'd0);
`else
      check($sformatf("reset_init_done%0d", i), 128'(init_done[i]), 128'd1);
`endif
    end
    rst_n = 1'b1;

`ifdef DMEM_INIT_CLEAR_EN
    wait_init(n);
    check("init_cycles", 128'(n), 128'd512);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("init_pulse_done_low", 128'(init_done[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    check("init_restart_cycles", 128'(n), 128'd512);
    model_reset();
`else
    @(negedge clk);
    check("nomacro_init_done", 128'(init_done[0]), 128'd1);
    check("nomacro_req_ready", 128'(req_ready[0]), 128'd1);
    @(posedge clk);
    #1;
`endif

    for (int i = 0; i < 6; i++) begin
      issue(0, 1'b0, 9'($urandom_range(0, 511)), 16'h0, 128'h0, w);
    end

    issue(0, 1'b1, 9'd5, 16'hFFFF, 128'h0, w);
    issue(0, 1'b1, 9'd5, 16'h0001, 128'h000000000000000000000000000000AA, w);
    issue(0, 1'b1, 9'd5, 16'h8000, 128'hBB000000000000000000000000000000, w);
    issue(0, 1'b1, 9'd5, 16'h0000, 128'h11111111111111111111111111111111, w);
    issue(0, 1'b0, 9'd5, 16'h0, 128'h0, w);

    issue(0, 1'b1, 9'd7, 16'hFFFF, 128'hDEADBEEF, w);
    check("b2b_write_wait", 128'(w), 128'd0);
    issue(0, 1'b0, 9'd7, 16'h0, 128'h0, w);
    check("b2b_read_wait", 128'(w), 128'd0);

    issue(0, 1'b0, 9'd5, 16'h0, 128'h0, w);
    resp_ready[0] = 1'b0;
    req_we[0]     = 1'b0;
    req_addr[0]   = 9'd7;
    req_valid[0]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_req_ready_%0d", k), 128'(req_ready[0]), 128'd0);
    end
    @(posedge clk);
    #1;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check("stall_release_ready", 128'(req_ready[0]), 128'd1);
    push_exp(0, 1'b0, 9'd7, 16'h0, 128'h0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;

    issue(1, 1'b1, 9'd299, 16'hFFFF, 128'h0123456789ABCDEF0011223344556677, w);
    issue(1, 1'b1, 9'd300, 16'hFFFF, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, w);
    issue(1, 1'b0, 9'd300, 16'h0, 128'h0, w);
    issue(1, 1'b0, 9'd511, 16'h0, 128'h0, w);
    issue(1, 1'b0, 9'd299, 16'h0, 128'h0, w);

    rand_rr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) a = 9'($urandom_range(0, 511));
      else a = 9'($urandom_range(0, 15) + ((d == 1) ? 292 : 0));
      case ($urandom_range(0, 7))
        0:       be = 16'h0000;
        1:       be = 16'hFFFF;
        default: be = 16'($urandom);
      endcase
      wd = {$urandom, $urandom, $urandom, $urandom};
      issue(d, 1'($urandom_range(0, 1)), a, be, wd, w);
    end
    rand_rr = 1'b0;
    @(posedge clk);
    #2;
    resp_ready = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    check("drain_q0", 128'(q0.size()), 128'd0);
    check("drain_q1", 128'(q1.size()), 128'd0);

    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 9'd7, 16'h0, 128'h0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 128'(resp_valid[0]), 128'd0);
    check("midrst_req_ready", 128'(req_ready[0]), 128'd0);
    check("midrst_resp_rdata", resp_rdata[0], 128'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 2'b11;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
